seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector; successor to the fixed single-pattern

---
 rtl/seq_detector_param.sv | 71 +++++++
 tb/tb_seq_detector_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial LEN-bit pattern detector with overlap/non-overlap modes and a saturating match counter.
// Latency: out is registered and pulses for one cycle, starting at the edge that samples the completing bit.
// Backpressure: none; valid=0 cycles freeze history, fill and count, and force out low.
module seq_detector_param #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inp,
    input  logic             valid,
    input  logic [LEN-1:0]   pattern,
    input  logic             overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    // fill only needs to reach LEN-1, so clog2(LEN) bits are enough for LEN >= 2
    localparam int FILL_W = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

    logic [LEN-1:0]   sh;
    logic [FILL_W-1:0] fill;

    logic [LEN-1:0]    cand;
    logic              full;
    logic              hit;
    logic              cnt_sat;
    logic [FILL_W-1:0] fill_nxt;
    logic [CNT_W-1:0]  count_nxt;

    // Candidate window, match decision and next fill/count values
    always_comb begin
        cand      = {sh[LEN-2:0], inp};
        full      = (fill == FILL_MAX);
        // fill gating keeps the all-zero reset history from matching pattern=0
        hit       = valid && full && (cand == pattern);
        cnt_sat   = &match_count;
        fill_nxt  = fill;
        count_nxt = match_count;

        if (hit && !overlap) begin
            // non-overlap: the next match must be built from LEN fresh bits
            fill_nxt = '0;
        end else if (!full) begin
            fill_nxt = fill + FILL_W'(1);
        end

        if (hit && !cnt_sat) begin
            count_nxt = match_count + CNT_W'(1);
        end
    end

    // State register: reset dominates; history only advances on valid bits
    always_ff @(posedge clock) begin
        if (reset) begin
            sh          <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else begin
            out <= hit;
            if (valid) begin
                sh          <= cand;
                fill        <= fill_nxt;
                match_count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlap modes, valid gaps, zero pattern, saturation, reset.
// Two instances share stimulus: the default CNT_W=8 one and a CNT_W=2 one for saturation.
// Inputs change #1 after the rising edge; outputs are sampled #1 after the next rising edge.
module tb_seq_detector_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       inp = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic       overlap = 1'b1;

    logic       out_a;
    logic [7:0] cnt_a;
    logic       out_b;
    logic [1:0] cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    seq_detector_param #(.LEN(4), .CNT_W(8)) dut_a (
        .clock      (clock),
        .reset      (reset),
        .inp        (inp),
        .valid      (valid),
        .pattern    (pattern),
        .overlap    (overlap),
        .out        (out_a),
        .match_count(cnt_a)
    );

    seq_detector_param #(.LEN(4), .CNT_W(2)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .inp        (inp),
        .valid      (valid),
        .pattern    (pattern),
        .overlap    (overlap),
        .out        (out_b),
        .match_count(cnt_b)
    );

    always #5 clock = ~clock;

    // One clock: apply (valid, bit), take the edge, settle past it
    task automatic send(input logic v, input logic b);
        valid = v;
        inp   = b;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        send(1'b1, 1'b1);
        tests_run++;
        if (out_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_a: got %b expected 0", out_a);
        end
        tests_run++;
        if (cnt_a !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt_a: got %0d expected 0", cnt_a);
        end
        tests_run++;
        if (out_b !== 1'b0 || cnt_b !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_b: got out=%b cnt=%0d expected out=0 cnt=0", out_b, cnt_b);
        end
        reset = 1'b0;
    endtask

    // Pattern 1010 on 10101010 with overlap: hits after bits 4, 6, 8
    task automatic test_overlap();
        logic [7:0] bits;
        logic [7:0] exp;
        bits = 8'b1010_1010;
        exp  = 8'b0001_0101;
        do_reset();
        pattern = 4'b1010;
        overlap = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send(1'b1, bits[i]);
            tests_run++;
            if (out_a !== exp[i]) begin
                tests_failed++;
                $display("FAIL overlap_out bit%0d: got %b expected %b", 8 - i, out_a, exp[i]);
            end
        end
        tests_run++;
        if (cnt_a !== 8'd3) begin
            tests_failed++;
            $display("FAIL overlap_count: got %0d expected 3", cnt_a);
        end
    endtask

    // Same stream without overlap: hits after bits 4 and 8 only
    task automatic test_nonoverlap();
        logic [7:0] bits;
        logic [7:0] exp;
        bits = 8'b1010_1010;
        exp  = 8'b0001_0001;
        do_reset();
        pattern = 4'b1010;
        overlap = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send(1'b1, bits[i]);
            tests_run++;
            if (out_a !== exp[i]) begin
                tests_failed++;
                $display("FAIL nonoverlap_out bit%0d: got %b expected %b", 8 - i, out_a, exp[i]);
            end
        end
        tests_run++;
        if (cnt_a !== 8'd2) begin
            tests_failed++;
            $display("FAIL nonoverlap_count: got %0d expected 2", cnt_a);
        end
    endtask

    // Overlap stream with three invalid garbage cycles after bit 2
    task automatic test_valid_gaps();
        logic [7:0] bits;
        logic [7:0] exp;
        bits = 8'b1010_1010;
        exp  = 8'b0001_0101;
        do_reset();
        pattern = 4'b1010;
        overlap = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i == 5) begin
                for (int g = 0; g < 3; g++) begin
                    send(1'b0, g[0] ? 1'b0 : 1'b1);
                    tests_run++;
                    if (out_a !== 1'b0 || cnt_a !== 8'd0) begin
                        tests_failed++;
                        $display("FAIL gap_hold cycle%0d: got out=%b cnt=%0d expected out=0 cnt=0",
                                 g, out_a, cnt_a);
                    end
                end
            end
            send(1'b1, bits[i]);
            tests_run++;
            if (out_a !== exp[i]) begin
                tests_failed++;
                $display("FAIL gap_out bit%0d: got %b expected %b", 8 - i, out_a, exp[i]);
            end
        end
        tests_run++;
        if (cnt_a !== 8'd3) begin
            tests_failed++;
            $display("FAIL gap_count: got %0d expected 3", cnt_a);
        end
    endtask

    // Pattern 0000: cleared history must not match before four real zeros
    task automatic test_zero_pattern();
        logic [5:0] exp;
        exp = 6'b000111;
        do_reset();
        pattern = 4'b0000;
        overlap = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            send(1'b1, 1'b0);
            tests_run++;
            if (out_a !== exp[i]) begin
                tests_failed++;
                $display("FAIL zero_out bit%0d: got %b expected %b", 6 - i, out_a, exp[i]);
            end
        end
        tests_run++;
        if (cnt_a !== 8'd3) begin
            tests_failed++;
            $display("FAIL zero_count: got %0d expected 3", cnt_a);
        end
    endtask

    // Pattern 1111 on ten ones: seven back-to-back pulses; 2-bit counter sticks at 3
    task automatic test_saturate();
        logic [9:0] exp;
        exp = 10'b00_0111_1111;
        do_reset();
        pattern = 4'b1111;
        overlap = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            send(1'b1, 1'b1);
            tests_run++;
            if (out_b !== exp[i]) begin
                tests_failed++;
                $display("FAIL sat_out bit%0d: got %b expected %b", 10 - i, out_b, exp[i]);
            end
        end
        tests_run++;
        if (cnt_b !== 2'd3) begin
            tests_failed++;
            $display("FAIL sat_count_b: got %0d expected 3", cnt_b);
        end
        tests_run++;
        if (cnt_a !== 8'd7) begin
            tests_failed++;
            $display("FAIL sat_count_a: got %0d expected 7", cnt_a);
        end
    endtask

    // 1,0,1 then reset (with valid high), then 0,1,0 and 1,0,1,0 non-overlapping
    task automatic test_reset_mid();
        logic [6:0] bits;
        logic [6:0] exp;
        // after reset the stream is 0,1,0,1,0,1,0; first full 1010 completes at bit 5
        bits = 7'b010_1010;
        exp  = 7'b000_0100;
        do_reset();
        pattern = 4'b1010;
        overlap = 1'b0;
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        reset = 1'b1;
        send(1'b1, 1'b0);
        reset = 1'b0;
        tests_run++;
        if (out_a !== 1'b0 || cnt_a !== 8'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got out=%b cnt=%0d expected out=0 cnt=0", out_a, cnt_a);
        end
        for (int i = 6; i >= 0; i--) begin
            send(1'b1, bits[i]);
            tests_run++;
            if (out_a !== exp[i]) begin
                tests_failed++;
                $display("FAIL midreset_out bit%0d: got %b expected %b", 7 - i, out_a, exp[i]);
            end
        end
        tests_run++;
        if (cnt_a !== 8'd1) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d expected 1", cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_valid_gaps();
        test_zero_pattern();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
